// File: rtl/handshake_arbiter.sv
// handshake_arbiter: round-robin front end that shares one handshake_reg
// staging register among N_REQ requesters. It latches the winner's word,
// walks the register's full/drain cycle and pulses src_ack to the winner.
// A drain watchdog aborts a stuck transfer and raises a sticky error flag.

module handshake_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 42,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           src_req,
    input  logic [N_REQ*WIDTH-1:0]     src_data,
    output logic [N_REQ-1:0]           src_ack,
    output logic                       reg_req,
    output logic [WIDTH-1:0]           reg_data,
    input  logic                       reg_ack,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    // Index of the last acknowledged winner; the scan starts one above it.
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_next;

    // Cycles spent in ISSUE+DRAIN for the current transfer.
    logic [CNT_W-1:0]   wd_cnt;
    logic [CNT_W-1:0]   wd_cnt_next;
    logic [CNT_W-1:0]   wd_cnt_inc;
    logic               wd_expire;

    logic [ID_W-1:0]    winner;
    logic               winner_found;
    logic               grant_fire;

    logic [N_REQ-1:0]   src_ack_next;
    logic               reg_req_next;
    logic [WIDTH-1:0]   reg_data_next;
    logic [ID_W-1:0]    grant_id_next;
    logic               busy_next;
    logic               timeout_err_next;

    // Adds an offset to a requester index with wrap-around at N_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int               offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    // Round-robin pick: first requester above the last winner, wrapping, the
    // last winner itself checked last so a lone requester is never skipped.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!winner_found && src_req[wrap_idx(rr_ptr, k)]) begin
                winner       = wrap_idx(rr_ptr, k);
                winner_found = 1'b1;
            end
        end
    end

    // Watchdog: saturating cycle count, expiring on the edge that completes
    // the TIMEOUT-th cycle of ISSUE+DRAIN; TIMEOUT of zero disables it.
    always_comb begin
        wd_cnt_inc = wd_cnt;
        if (wd_cnt != {CNT_W{1'b1}}) begin
            wd_cnt_inc = wd_cnt + CNT_W'(1);
        end
        wd_expire = 1'b0;
        if ((TIMEOUT != 0) && ((state == ST_ISSUE) || (state == ST_DRAIN))) begin
            wd_expire = (wd_cnt_inc == CNT_W'(TIMEOUT));
        end
    end

    // State register plus all registered outputs; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= ID_W'(N_REQ - 1);
            wd_cnt      <= '0;
            src_ack     <= '0;
            reg_req     <= 1'b0;
            reg_data    <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            wd_cnt      <= wd_cnt_next;
            src_ack     <= src_ack_next;
            reg_req     <= reg_req_next;
            reg_data    <= reg_data_next;
            grant_id    <= grant_id_next;
            busy        <= busy_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Next-state logic: the handshake sequence, pointer and watchdog count.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        wd_cnt_next = wd_cnt;
        case (state)
            ST_IDLE: begin
                // A full register here belongs to someone else; wait it out.
                if (winner_found && !reg_ack) begin
                    state_next  = ST_ISSUE;
                    wd_cnt_next = '0;
                end
            end
            ST_ISSUE: begin
                wd_cnt_next = wd_cnt_inc;
                if (wd_expire) begin
                    state_next = ST_DONE;
                end else if (reg_ack) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                wd_cnt_next = wd_cnt_inc;
                if (wd_expire) begin
                    state_next = ST_DONE;
                end else if (!reg_ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next  = ST_IDLE;
                rr_ptr_next = grant_id;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign grant_fire = (state == ST_IDLE) && (state_next == ST_ISSUE);

    // Output logic: next values of the registered outputs, derived from the
    // state being entered so every output changes on the same edge as state.
    always_comb begin
        reg_req_next     = (state_next == ST_ISSUE);
        busy_next        = (state_next != ST_IDLE);
        timeout_err_next = timeout_err | wd_expire;
        reg_data_next    = reg_data;
        grant_id_next    = grant_id;
        src_ack_next     = '0;
        if (grant_fire) begin
            reg_data_next = src_data[int'(winner)*WIDTH +: WIDTH];
            grant_id_next = winner;
        end
        if (state_next == ST_DONE) begin
            src_ack_next[grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_handshake_arbiter.sv
// tb_handshake_arbiter: directed test of handshake_arbiter with a behavioural
// staging register. Expected acknowledges go into a scoreboard queue when a
// request is issued; a monitor pops and compares them as src_ack pulses.

module tb_handshake_arbiter;

    localparam int N  = 4;
    localparam int W  = 42;
    localparam int TO = 8;

    typedef struct {
        logic [N-1:0] ack;
        logic [1:0]   gid;
        logic [W-1:0] data;
        logic         terr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     src_req = '0;
    logic [N*W-1:0]   src_data = '0;
    logic [N-1:0]     src_ack;
    logic             reg_req;
    logic [W-1:0]     reg_data;
    logic             reg_ack;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    // Staging register model: 0 = normal same-clock drain, 1 = ack stuck
    // high, 2 = dead register whose ack never rises.
    int               ack_mode = 0;
    logic             full;
    logic [W-1:0]     stage_data;

    int               vectors = 0;
    int               miscompares = 0;
    exp_t             exp_q[$];

    handshake_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_ack     (src_ack),
        .reg_req     (reg_req),
        .reg_data    (reg_data),
        .reg_ack     (reg_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Staging register: captures when empty and requested, drains a cycle later.
    always @(posedge clk) begin
        if (rst) begin
            full       <= 1'b0;
            stage_data <= '0;
        end else if (ack_mode == 0) begin
            if (!full && reg_req) begin
                full       <= 1'b1;
                stage_data <= reg_data;
            end else if (full) begin
                full <= 1'b0;
            end
        end
    end

    assign reg_ack = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'b0 : full;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [W-1:0] data,
                                 input bit push_exp, input bit terr_exp);
        exp_t e;
        src_data[idx*W +: W] = data;
        src_req[idx]         = 1'b1;
        if (push_exp) begin
            e.ack      = '0;
            e.ack[idx] = 1'b1;
            e.gid      = 2'(idx);
            e.data     = data;
            e.terr     = terr_exp;
            exp_q.push_back(e);
        end
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (src_ack != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_src_ack", 64'(src_ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_src_ack", 64'(src_ack), 64'(e.ack));
                    checkOutput("sb_grant_id", 64'(grant_id), 64'(e.gid));
                    checkOutput("sb_reg_data", 64'(reg_data), 64'(e.data));
                    checkOutput("sb_timeout_err", 64'(timeout_err), 64'(e.terr));
                end
            end
        end
    endtask

    // Advance to the next falling edge; optionally requesters drop on ack.
    task automatic step(input bit release_acks);
        @(negedge clk);
        if (release_acks) begin
            src_req = src_req & ~src_ack;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_reg_req"}, 64'(reg_req), 64'd0);
        checkOutput({tag, "_reg_data"}, 64'(reg_data), 64'd0);
        checkOutput({tag, "_src_ack"}, 64'(src_ack), 64'd0);
        checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        src_req  = '0;
        ack_mode = 0;
        exp_q.delete();
        step(0);
        step(0);
        checkResetValues("reset");
        rst = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        step(1);
        step(1);
    endtask

    initial begin
        int ack_cycles[$];
        int hi_cnt;
        int ack_k;

        fork
            monitorLoop();
        join_none

        // Single transfer through a same-clock drain.
        $display("[TB] single transfer");
        doReset();
        applyStimulus(0, 42'h123, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            checkOutput($sformatf("t1_reg_req_c%0d", k), 64'(reg_req), 64'(k <= 2));
            checkOutput($sformatf("t1_src_ack_c%0d", k), 64'(src_ack), (k == 4) ? 64'd1 : 64'd0);
            checkOutput($sformatf("t1_busy_c%0d", k), 64'(busy), 64'(k <= 4));
            if (k == 1) checkOutput("t1_reg_data", 64'(reg_data), 64'h123);
        end
        checkOutput("t1_stage_data", 64'(stage_data), 64'h123);
        waitDone(10, "t1_queue_drained");

        // All four requesters held high: strict rotation, five cycles apart.
        $display("[TB] round robin");
        doReset();
        for (int i = 0; i < N; i++) src_data[i*W +: W] = W'(42'h100 + i);
        applyStimulus(0, 42'h100, 1'b1, 1'b0);
        applyStimulus(1, 42'h101, 1'b1, 1'b0);
        applyStimulus(2, 42'h102, 1'b1, 1'b0);
        applyStimulus(3, 42'h103, 1'b1, 1'b0);
        applyStimulus(0, 42'h100, 1'b1, 1'b0);
        applyStimulus(1, 42'h101, 1'b1, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            step(0);
            if (src_ack != '0) ack_cycles.push_back(c);
            if (ack_cycles.size() == 6) begin
                src_req = '0;
                break;
            end
        end
        checkOutput("t2_ack_count", 64'(ack_cycles.size()), 64'd6);
        for (int i = 1; i < ack_cycles.size(); i++) begin
            checkOutput($sformatf("t2_spacing_%0d", i),
                        64'(ack_cycles[i] - ack_cycles[i-1]), 64'd5);
        end
        waitDone(10, "t2_queue_drained");

        // Register already full: no grant until it empties.
        $display("[TB] reg_ack stuck high");
        ack_mode = 1;
        applyStimulus(0, 42'h3A5, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checkOutput($sformatf("t3_reg_req_c%0d", k), 64'(reg_req), 64'd0);
            checkOutput($sformatf("t3_busy_c%0d", k), 64'(busy), 64'd0);
        end
        ack_mode = 0;
        waitDone(20, "t3_queue_drained");

        // Dead register: watchdog aborts after eight ISSUE cycles.
        $display("[TB] watchdog");
        ack_mode = 2;
        applyStimulus(1, 42'hBEEF, 1'b1, 1'b1);
        hi_cnt = 0;
        ack_k  = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (reg_req) hi_cnt++;
            if (src_ack != '0 && ack_k == 0) ack_k = k;
            if (k == 9) begin
                checkOutput("t4_timeout_err_set", 64'(timeout_err), 64'd1);
                checkOutput("t4_reg_req_dropped", 64'(reg_req), 64'd0);
            end
        end
        checkOutput("t4_issue_cycles", 64'(hi_cnt), 64'd8);
        checkOutput("t4_ack_cycle", 64'(ack_k), 64'd9);
        ack_mode = 0;
        applyStimulus(3, 42'h333, 1'b1, 1'b1);
        waitDone(20, "t4_queue_drained");
        checkOutput("t4_timeout_err_sticky", 64'(timeout_err), 64'd1);

        // Winner drops its request during DRAIN; a late requester waits.
        $display("[TB] winner drops mid transfer");
        doReset();
        applyStimulus(2, 42'h2222, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            if (k == 1) applyStimulus(0, 42'hAAA, 1'b1, 1'b0);
            if (k == 3) begin
                checkOutput("t5_in_drain_busy", 64'(busy), 64'd1);
                checkOutput("t5_in_drain_reg_req", 64'(reg_req), 64'd0);
                src_req[2]         = 1'b0;
                src_data[2*W +: W] = 42'h3_FFFF_FFFF;
            end
        end
        waitDone(30, "t5_queue_drained");

        // Reset during DRAIN aborts silently and restores requester 0 priority.
        $display("[TB] reset during drain");
        src_data[0*W +: W] = 42'h0F0;
        src_req[0]         = 1'b1;
        applyStimulus(1, 42'h111, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(0);
            if (k == 3) begin
                checkOutput("t6_in_drain_busy", 64'(busy), 64'd1);
                rst = 1'b1;
            end
        end
        step(0);
        checkResetValues("t6_after_rst");
        rst = 1'b0;
        applyStimulus(0, 42'h0F0, 1'b1, 1'b0);
        applyStimulus(1, 42'h111, 1'b1, 1'b0);
        waitDone(30, "t6_queue_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
